fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 128, operand/result width (32, 64 or 128).
REQ-002 SHALL have parameter FPU_LATENCY, default 1, cycles from o_fpu_valid to a valid i_fpu_output/i_fpu_exeption (range 1..15).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports i_cmd_valid in 1, o_cmd_ready out 1, i_cmd_mode in 3, i_cmd_op in 2, i_cmd_a in BIT_WIDTH, i_cmd_b in BIT_WIDTH, i_cmd_tag in 4: host command channel.
REQ-006 SHALL have ports o_fpu_valid out 1, o_fpu_mode out 3, o_fpu_operation out 2, o_fpu_inputA out BIT_WIDTH, o_fpu_inputB out BIT_WIDTH, i_fpu_output in BIT_WIDTH, i_fpu_exeption in 5: FPU-facing side.
REQ-007 SHALL have ports o_rsp_valid out 1, i_rsp_ready in 1, o_rsp_data out BIT_WIDTH, o_rsp_exeption out 5, o_rsp_tag out 4: response channel.
REQ-008 SHALL have ports o_busy out 1 (state != IDLE), o_sticky out 5, i_sticky_clr in 1.

Function
REQ-009 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one operation in flight.
REQ-010 IDLE: o_cmd_ready=1; on i_cmd_valid&o_cmd_ready SHALL register mode, op, a, b, tag and go to ISSUE.
REQ-011 ISSUE: o_fpu_valid=1 for exactly one cycle; load counter with FPU_LATENCY-1; go to WAIT.
REQ-012 WAIT: decrement counter each cycle; when counter==0 SHALL capture i_fpu_output and i_fpu_exeption into response registers and go to RESP.
REQ-013 o_fpu_mode/operation/inputA/inputB SHALL hold the registered command unchanged from ISSUE through end of WAIT.
REQ-014 RESP: o_rsp_valid=1 with data/exeption/tag stable until i_rsp_ready=1; on handshake go to IDLE.
REQ-015 o_cmd_ready SHALL be 0 in ISSUE, WAIT, RESP, including the RESP handshake cycle.
REQ-016 Latency: o_rsp_valid SHALL rise FPU_LATENCY+2 cycles after the command handshake cycle; minimum command period FPU_LATENCY+3 cycles.
REQ-017 Operation codes SHALL pass through unmodified (00 ADD, 01 SUB, 10 MUL, 11 DIV); mode values 5..7 pass through unmodified.
REQ-018 i_fpu_output/i_fpu_exeption SHALL be ignored outside the capture cycle.

Reset
REQ-019 On rst: state IDLE, counter 0, o_fpu_valid 0, o_rsp_valid 0, all data/tag/exeption/sticky registers and FPU-facing outputs 0; o_cmd_ready 1 from the first cycle after reset.
REQ-020 rst asserted mid-operation SHALL discard the in-flight command with no response.

Configuration
REQ-021 Macro FPU_ISSUE_STICKY_EN defined: o_sticky SHALL OR-accumulate o_rsp_exeption at each capture; i_sticky_clr clears it; clear and capture in the same cycle leaves o_sticky equal to the new exeption bits.
REQ-022 Macro FPU_ISSUE_STICKY_EN undefined: o_sticky SHALL be constant 0, i_sticky_clr ignored, no accumulation register.

Structure
REQ-023 Shared package fpu_pkg SHALL hold the FSM state encoding, mode and operation encodings, and exception bit indices ([4] overflow, [3] underflow, [2] divide-by-zero, [1] invalid, [0] inexact).
REQ-024 The sticky accumulator SHALL be sub-module fpu_flag_accum, instantiated only under FPU_ISSUE_STICKY_EN; all other logic in fpu_issue_ctrl.

Verification
REQ-025 ADD, mode 0, a=0x3FFF_0000..0 (1.0), b=0x4000_0000..0 (2.0), tag 5, FPU model latency 1 -> o_rsp_valid 3 cycles after handshake, data 0x4000_8000..0, exeption 0, tag 5.
REQ-026 i_rsp_ready held 0 for 10 cycles -> response stable, o_cmd_ready 0, o_fpu_valid pulses exactly once.
REQ-027 FPU_LATENCY=4, back-to-back i_cmd_valid -> second handshake 7 cycles after the first; o_fpu_valid period 7.
REQ-028 rst asserted in WAIT -> no o_rsp_valid; next command completes normally with its own tag.
REQ-029 STICKY_EN: responses with exeption 0x01 then 0x10 -> o_sticky 0x11; i_sticky_clr coincident with capture of 0x04 -> o_sticky 0x04; macro undefined -> o_sticky 0 throughout.

Source files
------------

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU issue controller and its flag accumulator:
//   - issue FSM state encoding
//   - FPU operation and mode encodings
//   - exception bit indices and widths
// Configuration macro used by the importing blocks: FPU_ISSUE_STICKY_EN
// ---------------------------------------------------------------------------
package fpu_pkg;

    // Issue controller FSM: one operation in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // FPU operation codes; these travel to the FPU untouched.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Mode field (rounding control). Values 5..7 are not named here but are
    // forwarded to the FPU exactly as received.
    localparam int          MODE_W   = 3;
    localparam logic [2:0]  MODE_RNE = 3'd0;
    localparam logic [2:0]  MODE_RTZ = 3'd1;
    localparam logic [2:0]  MODE_RDN = 3'd2;
    localparam logic [2:0]  MODE_RUP = 3'd3;
    localparam logic [2:0]  MODE_RMM = 3'd4;

    // Exception flag vector layout.
    localparam int EXC_W         = 5;
    localparam int EXC_OVERFLOW  = 4;
    localparam int EXC_UNDERFLOW = 3;
    localparam int EXC_DIV_ZERO  = 2;
    localparam int EXC_INVALID   = 1;
    localparam int EXC_INEXACT   = 0;

    // Command tag and latency counter widths (latency range 1..15).
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    // Value loaded into the wait counter so the capture lands exactly
    // FPU_LATENCY cycles after the o_fpu_valid pulse.
    function automatic logic [CNT_W-1:0] lat_preload(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/fpu_flag_accum.sv
// ---------------------------------------------------------------------------
// fpu_flag_accum
// Sticky exception accumulator. Each capture ORs the new flags into the
// sticky register; a clear empties it. When clear and capture coincide the
// result is exactly the newly captured flags.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   capture   : one-cycle strobe, flags are valid this cycle
//   clr       : clear request
//   flags     : exception flags being captured
//   sticky    : accumulated flags
// Only instantiated when FPU_ISSUE_STICKY_EN is defined.
// ---------------------------------------------------------------------------
module fpu_flag_accum
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             clr,
    input  logic [EXC_W-1:0] flags,
    output logic [EXC_W-1:0] sticky
);

    logic [EXC_W-1:0] sticky_reg;
    logic [EXC_W-1:0] sticky_next;

    always_comb begin
        sticky_next = clr ? '0 : sticky_reg;
        if (capture) begin
            sticky_next = sticky_next | flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_reg <= '0;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    assign sticky = sticky_reg;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
// Single-outstanding issue controller between a host command channel and a
// fixed-latency FPU. Flow: IDLE (accept) -> ISSUE (one-cycle o_fpu_valid)
// -> WAIT (count down FPU_LATENCY) -> RESP (hold response until taken).
// Parameters:
//   BIT_WIDTH   : operand/result width (32, 64 or 128)
//   FPU_LATENCY : cycles from o_fpu_valid to valid FPU result (1..15)
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   i_cmd_* / o_cmd_ready             : host command channel
//   o_fpu_* / i_fpu_output/exeption   : FPU-facing side
//   o_rsp_* / i_rsp_ready             : response channel
//   o_busy                            : controller not idle
//   o_sticky / i_sticky_clr           : sticky exception flags
// Configuration: define FPU_ISSUE_STICKY_EN to build the sticky accumulator;
// otherwise o_sticky is tied to zero and i_sticky_clr is ignored.
// ---------------------------------------------------------------------------
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int BIT_WIDTH   = 128,
    parameter int FPU_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    // host command channel
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [MODE_W-1:0]    i_cmd_mode,
    input  logic [1:0]           i_cmd_op,
    input  logic [BIT_WIDTH-1:0] i_cmd_a,
    input  logic [BIT_WIDTH-1:0] i_cmd_b,
    input  logic [TAG_W-1:0]     i_cmd_tag,
    // FPU side
    output logic                 o_fpu_valid,
    output logic [MODE_W-1:0]    o_fpu_mode,
    output logic [1:0]           o_fpu_operation,
    output logic [BIT_WIDTH-1:0] o_fpu_inputA,
    output logic [BIT_WIDTH-1:0] o_fpu_inputB,
    input  logic [BIT_WIDTH-1:0] i_fpu_output,
    input  logic [EXC_W-1:0]     i_fpu_exeption,
    // response channel
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [BIT_WIDTH-1:0] o_rsp_data,
    output logic [EXC_W-1:0]     o_rsp_exeption,
    output logic [TAG_W-1:0]     o_rsp_tag,
    // status
    output logic                 o_busy,
    output logic [EXC_W-1:0]     o_sticky,
    input  logic                 i_sticky_clr
);

    localparam logic [CNT_W-1:0] LAT_PRELOAD = lat_preload(FPU_LATENCY);

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   fpu_valid_reg;
    logic                   rsp_valid_reg;
    logic [MODE_W-1:0]      mode_reg;
    logic [1:0]             op_reg;
    logic [BIT_WIDTH-1:0]   a_reg;
    logic [BIT_WIDTH-1:0]   b_reg;
    logic [TAG_W-1:0]       tag_reg;
    logic [BIT_WIDTH-1:0]   rsp_data_reg;
    logic [EXC_W-1:0]       rsp_exc_reg;

    // The only cycle in which the FPU result bus is looked at.
    logic capture_en;
    assign capture_en = (state_reg == ST_WAIT) && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            fpu_valid_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            mode_reg      <= '0;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            tag_reg       <= '0;
            rsp_data_reg  <= '0;
            rsp_exc_reg   <= '0;
        end else begin
            // o_fpu_valid is a single-cycle pulse raised on entry to ISSUE.
            fpu_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        mode_reg      <= i_cmd_mode;
                        op_reg        <= i_cmd_op;
                        a_reg         <= i_cmd_a;
                        b_reg         <= i_cmd_b;
                        tag_reg       <= i_cmd_tag;
                        fpu_valid_reg <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_reg   <= LAT_PRELOAD;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (capture_en) begin
                        rsp_data_reg  <= i_fpu_output;
                        rsp_exc_reg   <= i_fpu_exeption;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is a pure decode of the state register, so it is low throughout
    // ISSUE/WAIT/RESP including the response handshake cycle.
    assign o_cmd_ready     = (state_reg == ST_IDLE);
    assign o_busy          = (state_reg != ST_IDLE);

    // Command registers only change on an accepted command, so the FPU
    // operands stay stable from ISSUE through the end of WAIT.
    assign o_fpu_valid     = fpu_valid_reg;
    assign o_fpu_mode      = mode_reg;
    assign o_fpu_operation = op_reg;
    assign o_fpu_inputA    = a_reg;
    assign o_fpu_inputB    = b_reg;

    assign o_rsp_valid     = rsp_valid_reg;
    assign o_rsp_data      = rsp_data_reg;
    assign o_rsp_exeption  = rsp_exc_reg;
    assign o_rsp_tag       = tag_reg;

`ifdef FPU_ISSUE_STICKY_EN
    fpu_flag_accum u_flag_accum (
        .clk     (clk),
        .rst     (rst),
        .capture (capture_en),
        .clr     (i_sticky_clr),
        .flags   (i_fpu_exeption),
        .sticky  (o_sticky)
    );
`else
    // No accumulator in this build; the clear input has nothing to act on.
    logic unused_sticky_clr;
    assign unused_sticky_clr = i_sticky_clr;
    assign o_sticky          = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue_ctrl
// Directed bench for fpu_issue_ctrl. Two instances share clk/rst:
//   u0 : BIT_WIDTH=128, FPU_LATENCY=1 (main function, stall, reset, sticky)
//   u4 : BIT_WIDTH=64,  FPU_LATENCY=4 (back-to-back throughput)
// Each FPU model presents the planned result only in the cycle the result is
// due and drives the inverted value at every other time.
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

    localparam int W0 = 128;
    localparam int L0 = 1;
    localparam int W4 = 64;
    localparam int L4 = 4;

`ifdef FPU_ISSUE_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- u0 signals ----------------
    logic          c_valid0, c_ready0;
    logic [2:0]    c_mode0;
    logic [1:0]    c_op0;
    logic [W0-1:0] c_a0, c_b0;
    logic [3:0]    c_tag0;
    logic          f_valid0;
    logic [2:0]    f_mode0;
    logic [1:0]    f_op0;
    logic [W0-1:0] f_a0, f_b0, f_out0;
    logic [4:0]    f_exc0;
    logic          r_valid0, r_ready0;
    logic [W0-1:0] r_data0;
    logic [4:0]    r_exc0;
    logic [3:0]    r_tag0;
    logic          busy0;
    logic [4:0]    sticky0;
    logic          sclr0;

    // ---------------- u4 signals ----------------
    logic          c_valid4, c_ready4;
    logic [2:0]    c_mode4;
    logic [1:0]    c_op4;
    logic [W4-1:0] c_a4, c_b4;
    logic [3:0]    c_tag4;
    logic          f_valid4;
    logic [2:0]    f_mode4;
    logic [1:0]    f_op4;
    logic [W4-1:0] f_a4, f_b4, f_out4;
    logic [4:0]    f_exc4;
    logic          r_valid4, r_ready4;
    logic [W4-1:0] r_data4;
    logic [4:0]    r_exc4;
    logic [3:0]    r_tag4;
    logic          busy4;
    logic [4:0]    sticky4;

    fpu_issue_ctrl #(.BIT_WIDTH(W0), .FPU_LATENCY(L0)) u0 (
        .clk(clk), .rst(rst),
        .i_cmd_valid(c_valid0), .o_cmd_ready(c_ready0), .i_cmd_mode(c_mode0),
        .i_cmd_op(c_op0), .i_cmd_a(c_a0), .i_cmd_b(c_b0), .i_cmd_tag(c_tag0),
        .o_fpu_valid(f_valid0), .o_fpu_mode(f_mode0), .o_fpu_operation(f_op0),
        .o_fpu_inputA(f_a0), .o_fpu_inputB(f_b0), .i_fpu_output(f_out0),
        .i_fpu_exeption(f_exc0),
        .o_rsp_valid(r_valid0), .i_rsp_ready(r_ready0), .o_rsp_data(r_data0),
        .o_rsp_exeption(r_exc0), .o_rsp_tag(r_tag0),
        .o_busy(busy0), .o_sticky(sticky0), .i_sticky_clr(sclr0)
    );

    fpu_issue_ctrl #(.BIT_WIDTH(W4), .FPU_LATENCY(L4)) u4 (
        .clk(clk), .rst(rst),
        .i_cmd_valid(c_valid4), .o_cmd_ready(c_ready4), .i_cmd_mode(c_mode4),
        .i_cmd_op(c_op4), .i_cmd_a(c_a4), .i_cmd_b(c_b4), .i_cmd_tag(c_tag4),
        .o_fpu_valid(f_valid4), .o_fpu_mode(f_mode4), .o_fpu_operation(f_op4),
        .o_fpu_inputA(f_a4), .o_fpu_inputB(f_b4), .i_fpu_output(f_out4),
        .i_fpu_exeption(f_exc4),
        .o_rsp_valid(r_valid4), .i_rsp_ready(r_ready4), .o_rsp_data(r_data4),
        .o_rsp_exeption(r_exc4), .o_rsp_tag(r_tag4),
        .o_busy(busy4), .o_sticky(sticky4), .i_sticky_clr(1'b0)
    );

    // ---------------- FPU models ----------------
    logic [W0-1:0] plan_res0 = '0;
    logic [4:0]    plan_exc0 = '0;
    logic [15:0]   pipe0     = '0;
    logic [W4-1:0] plan_res4 = '0;
    logic [4:0]    plan_exc4 = '0;
    logic [15:0]   pipe4     = '0;

    always @(posedge clk) begin
        pipe0 <= {pipe0[14:0], f_valid0};
        pipe4 <= {pipe4[14:0], f_valid4};
    end

    assign f_out0 = pipe0[L0-1] ? plan_res0 : ~plan_res0;
    assign f_exc0 = pipe0[L0-1] ? plan_exc0 : ~plan_exc0;
    assign f_out4 = pipe4[L4-1] ? plan_res4 : ~plan_res4;
    assign f_exc4 = pipe4[L4-1] ? plan_exc4 : ~plan_exc4;

    // ---------------- checking ----------------
    int nerr = 0;
    int nchk = 0;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on u0: issue, watch ISSUE/WAIT, check the
    // response, stall it for `hold` cycles, then take it.
    task automatic run0(input logic [2:0] mode, input logic [1:0] op,
                        input logic [W0-1:0] a, input logic [W0-1:0] b,
                        input logic [3:0] tag, input logic [W0-1:0] res,
                        input logic [4:0] exc, input int hold,
                        input bit clr_cap, input logic [4:0] exp_sticky);
        int lat;
        int pulses;
        plan_res0 = res;
        plan_exc0 = exc;
        c_valid0  = 1'b1;
        c_mode0   = mode;
        c_op0     = op;
        c_a0      = a;
        c_b0      = b;
        c_tag0    = tag;
        r_ready0  = 1'b0;
        check("cmd_ready_idle", 128'(c_ready0), 128'(1));
        tick();                       // command handshake edge
        c_valid0 = 1'b0;
        c_mode0  = '0;
        c_op0    = '0;
        c_a0     = '0;
        c_b0     = '0;
        c_tag0   = '0;
        lat      = 1;
        pulses   = 0;
        while (!r_valid0 && lat < 40) begin
            if (f_valid0) pulses++;
            check("cmd_ready_busy", 128'(c_ready0), 128'(0));
            check("fpu_inputA_hold", 128'(f_a0), 128'(a));
            check("fpu_inputB_hold", 128'(f_b0), 128'(b));
            check("fpu_mode_hold", 128'(f_mode0), 128'(mode));
            check("fpu_op_hold", 128'(f_op0), 128'(op));
            sclr0 = (clr_cap && lat == 1 + L0);
            tick();
            lat++;
        end
        sclr0 = 1'b0;
        check("rsp_latency", 128'(lat), 128'(L0 + 2));
        check("rsp_data", 128'(r_data0), 128'(res));
        check("rsp_exc", 128'(r_exc0), 128'(exc));
        check("rsp_tag", 128'(r_tag0), 128'(tag));
        check("sticky", 128'(sticky0), 128'(exp_sticky));
        for (int i = 0; i < hold; i++) begin
            tick();
            if (f_valid0) pulses++;
            check("stall_rsp_valid", 128'(r_valid0), 128'(1));
            check("stall_rsp_data", 128'(r_data0), 128'(res));
            check("stall_rsp_tag", 128'(r_tag0), 128'(tag));
            check("stall_cmd_ready", 128'(c_ready0), 128'(0));
        end
        r_ready0 = 1'b1;
        check("cmd_ready_rsp_hs", 128'(c_ready0), 128'(0));
        tick();
        r_ready0 = 1'b0;
        check("rsp_valid_after_hs", 128'(r_valid0), 128'(0));
        check("cmd_ready_after_hs", 128'(c_ready0), 128'(1));
        check("busy_after_hs", 128'(busy0), 128'(0));
        check("fpu_valid_pulses", 128'(pulses), 128'(1));
    endtask

    initial begin
        int hs[3];
        int fv[3];
        int nhs;
        int nfv;
        int frsp;
        bit saw_rsp;

        c_valid0 = 0; c_mode0 = 0; c_op0 = 0; c_a0 = 0; c_b0 = 0; c_tag0 = 0;
        r_ready0 = 0; sclr0 = 0;
        c_valid4 = 0; c_mode4 = 0; c_op4 = 0; c_a4 = 0; c_b4 = 0; c_tag4 = 0;
        r_ready4 = 0;

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) tick();
        check("rst_fpu_valid", 128'(f_valid0), 128'(0));
        check("rst_rsp_valid", 128'(r_valid0), 128'(0));
        check("rst_busy", 128'(busy0), 128'(0));
        check("rst_rsp_data", 128'(r_data0), 128'(0));
        check("rst_rsp_tag", 128'(r_tag0), 128'(0));
        check("rst_fpu_inputA", 128'(f_a0), 128'(0));
        check("rst_sticky", 128'(sticky0), 128'(0));
        rst = 1'b0;
        tick();
        check("ready_after_rst", 128'(c_ready0), 128'(1));

        // ---- ADD 1.0 + 2.0 = 3.0 (quad), tag 5 ----
        run0(3'd0, 2'b00, 128'h3FFF_0000_0000_0000_0000_0000_0000_0000,
             128'h4000_0000_0000_0000_0000_0000_0000_0000, 4'd5,
             128'h4000_8000_0000_0000_0000_0000_0000_0000, 5'h00, 0, 1'b0, 5'h00);

        // ---- MUL, mode 7, response stalled 10 cycles, inexact ----
        run0(3'd7, 2'b10, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
             128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 4'hA,
             128'hCAFE_F00D_0000_1234_5678_9ABC_DEF0_0001, 5'h01, 10, 1'b0,
             STICKY ? 5'h01 : 5'h00);

        // ---- DIV, mode 5, overflow -> sticky accumulates ----
        run0(3'd5, 2'b11, 128'h7FFE_0000_0000_0000_0000_0000_0000_0000,
             128'h0000_0000_0000_0000_0000_0000_0000_0001, 4'h3,
             128'h7FFF_0000_0000_0000_0000_0000_0000_0000, 5'h10, 0, 1'b0,
             STICKY ? 5'h11 : 5'h00);

        // ---- SUB, mode 6, clear coincident with divide-by-zero capture ----
        run0(3'd6, 2'b01, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5,
             128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A, 4'hF,
             128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 5'h04, 2, 1'b1,
             STICKY ? 5'h04 : 5'h00);

        // ---- reset while in WAIT discards the command ----
        plan_res0 = 128'hDEAD_BEEF;
        plan_exc0 = 5'h02;
        c_valid0  = 1'b1;
        c_mode0   = 3'd1;
        c_op0     = 2'b00;
        c_a0      = 128'h1;
        c_b0      = 128'h2;
        c_tag0    = 4'h9;
        tick();                       // handshake
        c_valid0 = 1'b0;
        tick();                       // now in WAIT
        check("busy_in_wait", 128'(busy0), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rsp_tag", 128'(r_tag0), 128'(0));
        check("midrst_rsp_data", 128'(r_data0), 128'(0));
        check("midrst_cmd_ready", 128'(c_ready0), 128'(1));
        check("midrst_sticky", 128'(sticky0), 128'(0));
        saw_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (r_valid0 || f_valid0) saw_rsp = 1'b1;
        end
        check("midrst_no_rsp", 128'(saw_rsp), 128'(0));
        run0(3'd2, 2'b10, 128'h4000_0000_0000_0000_0000_0000_0000_0000,
             128'h4000_0000_0000_0000_0000_0000_0000_0000, 4'hC,
             128'h4001_0000_0000_0000_0000_0000_0000_0000, 5'h00, 0, 1'b0, 5'h00);

        // ---- u4: back-to-back commands at FPU_LATENCY=4 ----
        plan_res4 = 64'h4010_0000_0000_0000;
        plan_exc4 = 5'h02;
        c_valid4  = 1'b1;
        c_mode4   = 3'd3;
        c_op4     = 2'b10;
        c_a4      = 64'h4000_0000_0000_0000;
        c_b4      = 64'h4000_0000_0000_0000;
        c_tag4    = 4'h6;
        r_ready4  = 1'b1;
        nhs  = 0;
        nfv  = 0;
        frsp = -1;
        for (int i = 0; i < 3; i++) begin
            hs[i] = -100;
            fv[i] = -100;
        end
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (c_valid4 && c_ready4 && nhs < 3) begin
                hs[nhs] = cyc;
                nhs++;
            end
            if (f_valid4 && nfv < 3) begin
                fv[nfv] = cyc;
                nfv++;
            end
            if (r_valid4 && frsp < 0) begin
                frsp = cyc;
                check("u4_rsp_data", 128'(r_data4), 128'(64'h4010_0000_0000_0000));
                check("u4_rsp_exc", 128'(r_exc4), 128'(5'h02));
                check("u4_rsp_tag", 128'(r_tag4), 128'(4'h6));
            end
            tick();
        end
        c_valid4 = 1'b0;
        check("u4_handshakes", 128'(nhs), 128'(3));
        check("u4_hs_period_1", 128'(hs[1] - hs[0]), 128'(L4 + 3));
        check("u4_hs_period_2", 128'(hs[2] - hs[1]), 128'(L4 + 3));
        check("u4_fpu_valid_period", 128'(fv[1] - fv[0]), 128'(L4 + 3));
        check("u4_issue_delay", 128'(fv[0] - hs[0]), 128'(1));
        check("u4_rsp_latency", 128'(frsp - hs[0]), 128'(L4 + 2));
        check("u4_sticky", 128'(sticky4), 128'(STICKY ? 5'h02 : 5'h00));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
